greyscaler_s_axi_regs: RTL and testbench
========================================

// Module: greyscaler_s_axi_regs
// PURPOSE
//  AXI4-Lite responder (slave) register file for the greyscaler control plane.
//  Answers the single-beat write/read traffic that the bus master issues.
//  Holds NUM_REGS 32-bit R/W registers and exports them to the pixel core.
//  Also exports a one-cycle pulse per register each time that register is written.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data width; only 32 is supported
//  C_S_AXI_ADDR_WIDTH  5   byte address width; word index = addr[ADDR_WIDTH-1:2]
//  NUM_REGS            4   implemented registers at 0x0,0x4,..; must be <= 2**(ADDR_WIDTH-2)
// PORTS
//  ACLK           in   1     clock, all logic rising-edge
//  ARESET         in   1     synchronous reset, active-high
//  S_AXI_AWADDR   in   AW    write address
//  S_AXI_AWPROT   in   3     ignored
//  S_AXI_AWVALID  in   1     write address valid
//  S_AXI_AWREADY  out  1     write address ready
//  S_AXI_WDATA    in   32    write data
//  S_AXI_WSTRB    in   4     byte enables
//  S_AXI_WVALID   in   1     write data valid
//  S_AXI_WREADY   out  1     write data ready
//  S_AXI_BRESP    out  2     00 OKAY, 10 SLVERR
//  S_AXI_BVALID   out  1     write response valid
//  S_AXI_BREADY   in   1     write response ready
//  S_AXI_ARADDR   in   AW    read address
//  S_AXI_ARPROT   in   3     ignored
//  S_AXI_ARVALID  in   1     read address valid
//  S_AXI_ARREADY  out  1     read address ready
//  S_AXI_RDATA    out  32    read data
//  S_AXI_RRESP    out  2     00 OKAY, 10 SLVERR
//  S_AXI_RVALID   out  1     read data valid
//  S_AXI_RREADY   in   1     read data ready
//  reg_q          out  32*NUM_REGS  register contents; reg i at [32*i +: 32]
//  reg_wr_pulse   out  NUM_REGS     1-cycle pulse when reg i is committed
// BEHAVIOUR
//  Reset:
//   - ARESET high at an edge clears all registers, held AW/W, and B/R state.
//   - Outputs after reset: all reg_q=0, all pulses=0.
//   - BVALID=0, RVALID=0, BRESP=RRESP=00, RDATA=0.
//   - AWREADY=WREADY=ARREADY=1 from the first cycle after reset.
//   - Reset mid-transaction drops the transaction; no response is issued.
//  Write channel:
//   - AW and W are accepted independently and in any order.
//   - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
//   - A handshake latches the address/data+strobe and sets the matching held flag.
//   - Commit happens on the edge after both flags are set (or when both handshake in the same cycle).
//   - At commit: bytes with WSTRB[b]=1 are updated, BVALID=1, reg_wr_pulse[i]=1 for one cycle.
//   - Both held flags clear at commit.
//   - Latency: last handshake in cycle N -> reg_q and BVALID updated at N+1.
//   - BVALID holds with a stable BRESP until BREADY; no new AW/W is accepted while BVALID=1.
//   - Index >= NUM_REGS: no register change, no pulse, BRESP=10.
//   - WSTRB=0 to a valid index: no change, pulse still asserted, BRESP=00.
//  Read channel:
//   - ARREADY = !RVALID.
//   - AR handshake in cycle N -> RVALID=1 at N+1, RDATA = register value in cycle N.
//   - If a write commits at the same edge, RDATA returns the pre-write value.
//   - RVALID/RDATA/RRESP hold until RREADY; the next AR can be accepted the cycle after the R handshake.
//   - Index >= NUM_REGS: RDATA=0, RRESP=10.
//  General:
//   - Read and write paths are independent and may complete in the same cycle.
//   - Address bits [1:0] are ignored.
// TESTING
//  - Reset, then write 1,2,3,4 to 0x0,0x4,0x8,0xC and read back -> read data 1,2,3,4, all RESP=00.
//  - W first (0xAABBCCDD), AW 3 cycles later to 0x4 -> no commit before AW; reg_q[63:32]=AABBCCDD and BVALID one cycle after AW handshake.
//  - Reg0=0x11223344, write 0xFFFFFFFF with WSTRB=0101 -> reg0=0x11FF33FF; pulse[0] high for exactly one cycle.
//  - Write/read 0x10 -> BRESP=10 with regs unchanged; RDATA=0 with RRESP=10.
//  - Hold BREADY and RREADY low for 5 cycles -> BVALID/RVALID, RESP and data stay stable; AWREADY, WREADY and ARREADY stay 0.
//  - Assert ARESET while BVALID=1 after writing 0x5 -> BVALID=0 and reg_q=0 next cycle; a new write completes normally.

Source files
------------

// File: rtl/greyscaler_s_axi_regs.sv
`default_nettype none
// ============================================================================
// Module   : greyscaler_s_axi_regs
// Brief    : AXI4-Lite responder holding the greyscaler control registers,
//            with a one-cycle commit pulse per register.
// Revision : 1.0  initial release
// ============================================================================
module greyscaler_s_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   ACLK,
    input  logic                                   ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_q,
    output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

    localparam int         DW          = C_S_AXI_DATA_WIDTH;
    localparam int         SW          = DW / 8;
    localparam int         AW          = C_S_AXI_ADDR_WIDTH;
    localparam int         IW          = AW - 2;
    localparam logic [1:0] C_RESP_OKAY = 2'b00;
    localparam logic [1:0] C_RESP_SLV  = 2'b10;

    logic [DW-1:0]       regs_q [NUM_REGS];
    logic [DW-1:0]       regs_d [NUM_REGS];
    logic                aw_held_q, aw_held_d;
    logic [IW-1:0]       awidx_q, awidx_d;
    logic                w_held_q, w_held_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [SW-1:0]       wstrb_q, wstrb_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [NUM_REGS-1:0] pulse_q, pulse_d;

    logic          w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [IW-1:0] w_wr_idx, w_rd_idx;
    logic [DW-1:0] w_wr_data;
    logic [SW-1:0] w_wr_strb;
    logic          w_wr_hit, w_rd_hit;
    logic          w_unused;

    assign S_AXI_AWREADY = !aw_held_q && !bvalid_q;
    assign S_AXI_WREADY  = !w_held_q && !bvalid_q;
    assign S_AXI_ARREADY = !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign reg_wr_pulse  = pulse_q;

    assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A handshake in this cycle counts as held, so a same-cycle AW+W commits at once.
    assign w_commit  = (aw_held_q || w_aw_hs) && (w_held_q || w_w_hs);
    assign w_wr_idx  = aw_held_q ? awidx_q : S_AXI_AWADDR[AW-1:2];
    assign w_wr_data = w_held_q ? wdata_q : S_AXI_WDATA;
    assign w_wr_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;
    assign w_rd_idx  = S_AXI_ARADDR[AW-1:2];
    assign w_wr_hit  = int'(w_wr_idx) < NUM_REGS;
    assign w_rd_hit  = int'(w_rd_idx) < NUM_REGS;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
            assign reg_q[DW*gi +: DW] = regs_q[gi];
        end
    endgenerate

    always_comb begin
        regs_d    = regs_q;
        aw_held_d = aw_held_q;
        awidx_d   = awidx_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        pulse_d   = '0;

        if (w_aw_hs) begin
            aw_held_d = 1'b1;
            awidx_d   = S_AXI_AWADDR[AW-1:2];
        end
        if (w_w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
        end
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (w_commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_wr_hit ? C_RESP_OKAY : C_RESP_SLV;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (int'(w_wr_idx) == i) begin
                    pulse_d[i] = 1'b1;
                    for (int b = 0; b < SW; b++) begin
                        if (w_wr_strb[b]) begin
                            regs_d[i][8*b +: 8] = w_wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end

        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        // Reads sample regs_q, so a write committing on the same edge is not visible.
        if (w_ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = w_rd_hit ? C_RESP_OKAY : C_RESP_SLV;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (int'(w_rd_idx) == i) begin
                    rdata_d = regs_q[i];
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            aw_held_q <= 1'b0;
            awidx_q   <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= C_RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= C_RESP_OKAY;
            pulse_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            aw_held_q <= aw_held_d;
            awidx_q   <= awidx_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            pulse_q   <= pulse_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_greyscaler_s_axi_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_greyscaler_s_axi_regs
// Brief    : Directed, table-driven bench for the greyscaler AXI4-Lite registers.
// Revision : 1.0  initial release
// ============================================================================
module tb_greyscaler_s_axi_regs;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [4:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [4:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] reg_q;
    logic [3:0]   reg_wr_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    greyscaler_s_axi_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .NUM_REGS(4)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        int n = 0;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
        while (!(aw_done && w_done) && n < 20) begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
            if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
            tick();
            n++;
            if (aw_done) S_AXI_AWVALID = 0;
            if (w_done) S_AXI_WVALID = 0;
        end
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) timeout_fail("wr_bvalid");
        resp = S_AXI_BRESP;
        tick();
        S_AXI_BREADY = 0;
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
        while (!S_AXI_ARREADY && n < 20) begin
            tick();
            n++;
        end
        tick();
        S_AXI_ARVALID = 0;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) timeout_fail("rd_rvalid");
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        S_AXI_RREADY = 1;
        tick();
        S_AXI_RREADY = 0;
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [1:0]  rr;

        vecs[0] = '{5'h00, 32'h1,        4'hF, 2'b00, 32'h1,  2'b00};
        vecs[1] = '{5'h04, 32'h2,        4'hF, 2'b00, 32'h2,  2'b00};
        vecs[2] = '{5'h08, 32'h3,        4'hF, 2'b00, 32'h3,  2'b00};
        vecs[3] = '{5'h0C, 32'h4,        4'hF, 2'b00, 32'h4,  2'b00};
        vecs[4] = '{5'h10, 32'hDEAD,     4'hF, 2'b10, 32'h0,  2'b10};
        vecs[5] = '{5'h00, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h1,  2'b00};
        vecs[6] = '{5'h07, 32'h55,       4'hF, 2'b00, 32'h55, 2'b00};

        ARESET = 1;
        S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
        S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
        S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
        tick();
        tick();
        ARESET = 0;

        check("rst_regs", reg_q, 128'h0);
        check("rst_pulse", {124'h0, reg_wr_pulse}, 128'h0);
        check("rst_b_r", {S_AXI_BVALID, S_AXI_BRESP, S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA},
              {1'b0, 2'b00, 1'b0, 2'b00, 32'h0});
        check("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        for (int i = 0; i < 7; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
            check($sformatf("vec%0d_bresp", i), resp, vecs[i].bresp);
            do_read(vecs[i].addr, rd, rr);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d_rresp", i), rr, vecs[i].rresp);
        end
        check("table_regs", reg_q, {32'h4, 32'h3, 32'h55, 32'h1});

        // W ahead of AW: nothing commits until the address arrives.
        S_AXI_WDATA = 32'hAABBCCDD; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
        check("wfirst_wready", S_AXI_WREADY, 1'b1);
        tick();
        S_AXI_WVALID = 0;
        for (int k = 0; k < 3; k++) begin
            check("wfirst_no_commit", {S_AXI_BVALID, reg_q[63:32]}, {1'b0, 32'h55});
            tick();
        end
        check("wfirst_wready_held", S_AXI_WREADY, 1'b0);
        S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1;
        tick();
        S_AXI_AWVALID = 0;
        check("wfirst_commit", {S_AXI_BVALID, S_AXI_BRESP, reg_q[63:32]}, {1'b1, 2'b00, 32'hAABBCCDD});
        check("wfirst_pulse", reg_wr_pulse, 4'b0010);
        S_AXI_BREADY = 1;
        tick();
        S_AXI_BREADY = 0;
        check("wfirst_b_done", {S_AXI_BVALID, reg_wr_pulse}, {1'b0, 4'b0000});

        // Byte strobes with a one-cycle pulse.
        do_write(5'h00, 32'h11223344, 4'hF, resp);
        S_AXI_AWADDR = 5'h00; S_AXI_WDATA = 32'hFFFFFFFF; S_AXI_WSTRB = 4'b0101;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
        tick();
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        check("strb_reg0", reg_q[31:0], 32'h11FF33FF);
        check("strb_pulse_on", reg_wr_pulse, 4'b0001);
        tick();
        S_AXI_BREADY = 0;
        check("strb_pulse_off", {S_AXI_BVALID, reg_wr_pulse}, {1'b0, 4'b0000});

        // Back-pressure on both responses; the read races a write to the same register.
        S_AXI_AWADDR = 5'h08; S_AXI_WDATA = 32'h99; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARADDR = 5'h08; S_AXI_ARVALID = 1;
        tick();
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        check("race_reg2", reg_q[95:64], 32'h99);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold",
                  {S_AXI_BVALID, S_AXI_BRESP, S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA,
                   S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY},
                  {1'b1, 2'b00, 1'b1, 2'b00, 32'h3, 3'b000});
            tick();
        end
        S_AXI_BREADY = 1; S_AXI_RREADY = 1;
        tick();
        S_AXI_BREADY = 0; S_AXI_RREADY = 0;
        check("bp_release",
              {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY},
              5'b00111);

        // Reset while a write response is pending.
        S_AXI_AWADDR = 5'h05; S_AXI_WDATA = 32'h1234; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
        tick();
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        check("rstmid_pending", {S_AXI_BVALID, reg_q[63:32]}, {1'b1, 32'h1234});
        ARESET = 1;
        tick();
        ARESET = 0;
        check("rstmid_cleared", {S_AXI_BVALID, reg_q}, {1'b0, 128'h0});
        check("rstmid_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        do_write(5'h08, 32'h77, 4'hF, resp);
        check("rstmid_bresp", resp, 2'b00);
        do_read(5'h08, rd, rr);
        check("rstmid_rdata", {rr, rd}, {2'b00, 32'h77});
        check("rstmid_regs", reg_q, {32'h0, 32'h77, 32'h0, 32'h0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
